lsu_split: RTL and testbench

Parametrised memory-stage load/store unit: the next generation of the single-cycle memory stage. It accepts one load/store per handshake and drives a valid/ready data-memory port with byte masks. Loads are lane-extracted and sign/zero-extended. Accesses that cross a data-word boundary are split into two memory beats. The result is returned to writeback with a one-cycle valid pulse, and the pipeline is stalled while the access is in flight.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu_split.sv | 224 ++++++++++++++++++++++
 tb/tb_lsu_split.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-select encodings,
// FSM state type and the access-size helper.
package lsu_pkg;

    localparam logic [2:0] SEL_LB  = 3'b000;
    localparam logic [2:0] SEL_LH  = 3'b001;
    localparam logic [2:0] SEL_LW  = 3'b010;
    localparam logic [2:0] SEL_LD  = 3'b011;
    localparam logic [2:0] SEL_LBU = 3'b100;
    localparam logic [2:0] SEL_LHU = 3'b101;
    localparam logic [2:0] SEL_LWU = 3'b110;
    localparam logic [2:0] SEL_SB  = 3'b000;
    localparam logic [2:0] SEL_SH  = 3'b001;
    localparam logic [2:0] SEL_SW  = 3'b010;
    localparam logic [2:0] SEL_SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_e;

    // Access size in bytes: 1, 2, 4 or 8.
    function automatic logic [3:0] lsu_size(input logic [2:0] sel);
        return 4'b0001 << sel[1:0];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane positioning for stores (mask, data across a two-word window)
// and lane extraction plus sign/zero extension for loads. Purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NB     = DATA_W / 8,
    parameter int OFF_W  = $clog2(NB)
) (
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata_lo,
    input  logic [DATA_W-1:0] rdata_hi,
    output logic [NB-1:0]     mask0,
    output logic [NB-1:0]     mask1,
    output logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] ld_data
);

    logic [3:0]          size;
    logic [NB-1:0]       lane_keep;
    logic [2*NB-1:0]     mask_win;
    logic [2*DATA_W-1:0] wdata_win;
    logic [2*DATA_W-1:0] rdata_win;
    logic [DATA_W-1:0]   keep;
    logic [DATA_W-1:0]   raw;
    logic                sbit;

    always_comb begin
        size      = lsu_size(sel);
        lane_keep = ~({NB{1'b1}} << size);
        mask_win  = {{NB{1'b0}}, lane_keep} << off;
        wdata_win = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
        rdata_win = {rdata_hi, rdata_lo} >> {off, 3'b000};
        keep      = ~({DATA_W{1'b1}} << {size, 3'b000});
        raw       = rdata_win[DATA_W-1:0] & keep;
        // keep ^ (keep >> 1) isolates the top kept bit, i.e. the sign bit
        sbit      = |(raw & (keep ^ (keep >> 1)));
        ld_data   = (sbit && !sel[2]) ? (raw | ~keep) : raw;
    end

    assign mask0  = mask_win[NB-1:0];
    assign mask1  = mask_win[2*NB-1:NB];
    assign wdata0 = wdata_win[DATA_W-1:0];
    assign wdata1 = wdata_win[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/lsu_split.sv
// Memory-stage load/store unit with valid/ready memory port and writeback pulse.
// Define LSU_SPLIT_MISALIGN_EN to split word-crossing accesses into two beats.
//
// state   | meaning
// IDLE    | ready for a request
// REQ     | memory beat presented, waiting for mem_ready_i
// WAIT    | beat accepted, waiting for mem_rvalid_i
// DONE    | writeback pulse, back to IDLE next cycle
module lsu_split
    import lsu_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int RADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [2:0]           req_sel_i,
    input  logic [ADDR_W-1:0]    req_addr_i,
    input  logic [DATA_W-1:0]    req_wdata_i,
    input  logic [RADDR_W-1:0]   req_rd_addr_i,
    input  logic [ADDR_W-1:0]    req_pc_i,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic                 mem_we_o,
    output logic [DATA_W/8-1:0]  mem_wmask_o,
    output logic [DATA_W-1:0]    mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic [DATA_W-1:0]    mem_rdata_i,
    output logic                 wb_valid_o,
    output logic                 wb_rd_ena_o,
    output logic [RADDR_W-1:0]   wb_rd_addr_o,
    output logic [DATA_W-1:0]    wb_rd_data_o,
    output logic [ADDR_W-1:0]    wb_pc_o,
    output logic                 misalign_o,
    output logic                 stall_req_o
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
`ifdef LSU_SPLIT_MISALIGN_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_e state_q, state_n;

    logic                we_q, split_q, beat_q;
    logic [2:0]          sel_q;
    logic [OFF_W-1:0]    off_q;
    logic [ADDR_W-1:0]   base_q, pc_q;
    logic [DATA_W-1:0]   wdata_q, rdata0_q;
    logic [RADDR_W-1:0]  rd_q;

    logic [OFF_W-1:0]    req_off;
    logic [3:0]          req_size;
    logic [ADDR_W-1:0]   req_base;
    logic                req_cross, req_fault, capture, second_beat;

    logic                req_ready_n, mem_valid_n, mem_we_n, stall_n;
    logic                wb_valid_n, wb_rd_ena_n, misalign_n;
    logic [ADDR_W-1:0]   mem_addr_n, wb_pc_n;
    logic [NB-1:0]       mem_wmask_n, mask0, mask1;
    logic [DATA_W-1:0]   mem_wdata_n, wb_rd_data_n, wdata0, wdata1, ld_data;
    logic [RADDR_W-1:0]  wb_rd_addr_n;

    always_comb begin
        req_off   = req_addr_i[OFF_W-1:0];
        req_size  = lsu_size(req_sel_i);
        req_base  = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        req_cross = (int'(req_off) + int'(req_size)) > NB;
        req_fault = (int'(req_size) > NB) || (req_cross && !SPLIT_EN);
    end

    assign capture     = (state_q == ST_IDLE) && req_valid_i;
    assign second_beat = (state_q == ST_WAIT) && mem_rvalid_i && split_q && !beat_q;

    // In IDLE the aligner sees the incoming request so beat 0 can be registered on accept.
    lsu_align #(.DATA_W(DATA_W)) u_align (
        .off      ((state_q == ST_IDLE) ? req_off : off_q),
        .sel      ((state_q == ST_IDLE) ? req_sel_i : sel_q),
        .wdata    ((state_q == ST_IDLE) ? req_wdata_i : wdata_q),
        .rdata_lo (beat_q ? rdata0_q : mem_rdata_i),
        .rdata_hi (mem_rdata_i),
        .mask0    (mask0),
        .mask1    (mask1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_n      = state_q;
        req_ready_n  = req_ready_o;
        mem_valid_n  = mem_valid_o;
        mem_addr_n   = mem_addr_o;
        mem_we_n     = mem_we_o;
        mem_wmask_n  = mem_wmask_o;
        mem_wdata_n  = mem_wdata_o;
        stall_n      = stall_req_o;
        wb_valid_n   = 1'b0;
        wb_rd_ena_n  = 1'b0;
        misalign_n   = 1'b0;
        wb_rd_addr_n = wb_rd_addr_o;
        wb_rd_data_n = wb_rd_data_o;
        wb_pc_n      = wb_pc_o;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    req_ready_n = 1'b0;
                    if (req_fault) begin
                        state_n      = ST_DONE;
                        wb_valid_n   = 1'b1;
                        misalign_n   = 1'b1;
                        wb_rd_data_n = '0;
                        wb_rd_addr_n = req_rd_addr_i;
                        wb_pc_n      = req_pc_i;
                    end else begin
                        state_n     = ST_REQ;
                        mem_valid_n = 1'b1;
                        mem_addr_n  = req_base;
                        mem_we_n    = req_we_i;
                        mem_wmask_n = mask0;
                        mem_wdata_n = wdata0;
                        stall_n     = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ready_i) begin
                    state_n     = ST_WAIT;
                    mem_valid_n = 1'b0;
                end
            end
            ST_WAIT: begin
                if (second_beat) begin
                    state_n     = ST_REQ;
                    mem_valid_n = 1'b1;
                    mem_addr_n  = base_q + ADDR_W'(NB);
                    mem_wmask_n = mask1;
                    mem_wdata_n = wdata1;
                end else if (mem_rvalid_i) begin
                    state_n      = ST_DONE;
                    stall_n      = 1'b0;
                    wb_valid_n   = 1'b1;
                    wb_rd_ena_n  = !we_q;
                    wb_rd_addr_n = rd_q;
                    wb_pc_n      = pc_q;
                    wb_rd_data_n = we_q ? '0 : ld_data;
                end
            end
            ST_DONE: begin
                state_n     = ST_IDLE;
                req_ready_n = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_ready_o  <= 1'b1;
            mem_valid_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_we_o     <= 1'b0;
            mem_wmask_o  <= '0;
            mem_wdata_o  <= '0;
            stall_req_o  <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_rd_ena_o  <= 1'b0;
            misalign_o   <= 1'b0;
            wb_rd_addr_o <= '0;
            wb_rd_data_o <= '0;
            wb_pc_o      <= '0;
        end else begin
            state_q      <= state_n;
            req_ready_o  <= req_ready_n;
            mem_valid_o  <= mem_valid_n;
            mem_addr_o   <= mem_addr_n;
            mem_we_o     <= mem_we_n;
            mem_wmask_o  <= mem_wmask_n;
            mem_wdata_o  <= mem_wdata_n;
            stall_req_o  <= stall_n;
            wb_valid_o   <= wb_valid_n;
            wb_rd_ena_o  <= wb_rd_ena_n;
            misalign_o   <= misalign_n;
            wb_rd_addr_o <= wb_rd_addr_n;
            wb_rd_data_o <= wb_rd_data_n;
            wb_pc_o      <= wb_pc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q  <= 1'b0;
            split_q <= 1'b0;
        end else if (capture) begin
            beat_q  <= 1'b0;
            split_q <= req_cross;
        end else if (second_beat) begin
            beat_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            we_q    <= req_we_i;
            sel_q   <= req_sel_i;
            off_q   <= req_off;
            base_q  <= req_base;
            wdata_q <= req_wdata_i;
            rd_q    <= req_rd_addr_i;
            pc_q    <= req_pc_i;
        end
        if (second_beat) rdata0_q <= mem_rdata_i;
    end

endmodule

// File: tb/tb_lsu_split.sv
// Scoreboard bench for lsu_split (DATA_W=64): expected beats and writeback
// results are queued at issue time and compared as the DUT produces them.
module tb_lsu_split;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_we_i = 1'b0;
    logic [2:0]    req_sel_i = 3'b000;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic [RW-1:0] req_rd_addr_i = '0;
    logic [AW-1:0] req_pc_i = '0;
    logic          mem_valid_o;
    logic          mem_ready_i = 1'b1;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [7:0]    mem_wmask_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          wb_valid_o;
    logic          wb_rd_ena_o;
    logic [RW-1:0] wb_rd_addr_o;
    logic [DW-1:0] wb_rd_data_o;
    logic [AW-1:0] wb_pc_o;
    logic          misalign_o;
    logic          stall_req_o;

    lsu_split #(.DATA_W(DW), .ADDR_W(AW), .RADDR_W(RW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_sel_i(req_sel_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_rd_addr_i(req_rd_addr_i), .req_pc_i(req_pc_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_wmask_o(mem_wmask_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rd_ena_o(wb_rd_ena_o), .wb_rd_addr_o(wb_rd_addr_o),
        .wb_rd_data_o(wb_rd_data_o), .wb_pc_o(wb_pc_o),
        .misalign_o(misalign_o), .stall_req_o(stall_req_o)
    );

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  mask;
        logic        we;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } beat_t;

    typedef struct {
        logic [63:0] data;
        logic        ena;
        logic        mis;
        logic [4:0]  rd;
        logic [63:0] pc;
        int          cyc;
    } wb_t;

    beat_t beat_q[$];
    wb_t   sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    resp_delay = 0;
    int    rd_ctr = 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_beat(input logic [63:0] a, input logic [7:0] m, input logic w,
                             input logic [63:0] wd, input logic [63:0] rd);
        beat_t b;
        b.addr = a; b.mask = m; b.we = w; b.wdata = wd; b.rdata = rd;
        beat_q.push_back(b);
    endtask

    // Issues one request; returns #1 after the accepting edge.
    task automatic do_req(input logic we, input logic [2:0] sel, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] exp_data,
                          input logic exp_ena, input logic exp_mis, input int lat,
                          input bit expect_wb);
        int  t = 0;
        wb_t e;
        @(negedge clk);
        while (!req_ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("req_ready", req_ready_o, 1'b1);
        req_valid_i   = 1'b1;
        req_we_i      = we;
        req_sel_i     = sel;
        req_addr_i    = addr;
        req_wdata_i   = wdata;
        req_rd_addr_i = rd_ctr[4:0];
        req_pc_i      = 64'h8000_0000 + 64'(rd_ctr * 4);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        if (expect_wb) begin
            e.data = exp_data; e.ena = exp_ena; e.mis = exp_mis;
            e.rd = rd_ctr[4:0]; e.pc = 64'h8000_0000 + 64'(rd_ctr * 4);
            e.cyc = cyc - 1 + lat;
            sb.push_back(e);
        end
        rd_ctr++;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((sb.size() != 0 || beat_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_wb", 64'(sb.size()), 64'd0);
        check("drain_beats", 64'(beat_q.size()), 64'd0);
    endtask

    // Memory responder: one response per accepted beat, resp_delay extra cycles late.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (mem_valid_o && mem_ready_i && !rst) begin
                if (beat_q.size() == 0) begin
                    check("unexp_beat", 64'd1, 64'd0);
                    b = '{addr: 0, mask: 0, we: 0, wdata: 0, rdata: 0};
                end else begin
                    b = beat_q.pop_front();
                    check("beat_addr", mem_addr_o, b.addr);
                    check("beat_mask", 64'(mem_wmask_o), 64'(b.mask));
                    check("beat_we", 64'(mem_we_o), 64'(b.we));
                    if (b.we) check("beat_wdata", mem_wdata_o, b.wdata);
                end
                @(posedge clk);
                #1;
                repeat (resp_delay) begin
                    @(posedge clk);
                    #1;
                end
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = b.rdata;
                @(posedge clk);
                #1;
                mem_rvalid_i = 1'b0;
            end
        end
    end

    // Writeback monitor.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (wb_valid_o) begin
                if (sb.size() == 0) begin
                    check("unexp_wb", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("wb_cycle", 64'(cyc), 64'(e.cyc));
                    check("wb_data", wb_rd_data_o, e.data);
                    check("wb_ena", 64'(wb_rd_ena_o), 64'(e.ena));
                    check("wb_misalign", 64'(misalign_o), 64'(e.mis));
                    check("wb_rd", 64'(wb_rd_addr_o), 64'(e.rd));
                    check("wb_pc", wb_pc_o, e.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d errors so far", n_err);
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] RW0 = 64'h1122_3344_A566_7788;

    typedef struct {
        logic [2:0]  sel;
        logic [63:0] addr;
        logic [7:0]  mask;
        logic [63:0] exp;
    } ld_vec_t;

    ld_vec_t ld_tab[7];

    initial begin
        ld_tab[0] = '{sel: 3'b100, addr: 64'h2003, mask: 8'h08, exp: 64'h0000_0000_0000_00A5};
        ld_tab[1] = '{sel: 3'b000, addr: 64'h2003, mask: 8'h08, exp: 64'hFFFF_FFFF_FFFF_FFA5};
        ld_tab[2] = '{sel: 3'b101, addr: 64'h2002, mask: 8'h0C, exp: 64'h0000_0000_0000_A566};
        ld_tab[3] = '{sel: 3'b001, addr: 64'h2002, mask: 8'h0C, exp: 64'hFFFF_FFFF_FFFF_A566};
        ld_tab[4] = '{sel: 3'b110, addr: 64'h2004, mask: 8'hF0, exp: 64'h0000_0000_1122_3344};
        ld_tab[5] = '{sel: 3'b011, addr: 64'h2000, mask: 8'hFF, exp: RW0};
        ld_tab[6] = '{sel: 3'b010, addr: 64'h2000, mask: 8'h0F, exp: 64'hFFFF_FFFF_A566_7788};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(req_ready_o), 64'd1);
        check("rst_mem_valid", 64'(mem_valid_o), 64'd0);
        check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        check("rst_stall", 64'(stall_req_o), 64'd0);
        check("rst_misalign", 64'(misalign_o), 64'd0);
        check("rst_mem_addr", mem_addr_o, 64'd0);
        rst = 1'b0;

        // Aligned LW, negative word sign-extends.
        push_beat(64'h1000, 8'h0F, 1'b0, 64'h0, 64'h0000_0000_8000_0001);
        do_req(1'b0, 3'b010, 64'h1000, 64'h0, 64'hFFFF_FFFF_8000_0001, 1'b1, 1'b0, 3, 1'b1);
        @(negedge clk);
        check("stall_in_req", 64'(stall_req_o), 64'd1);
        wait_done();

        // Unaligned SH inside one word.
        push_beat(64'h1000, 8'hC0, 1'b1, 64'hBEEF_0000_0000_0000, 64'h0);
        do_req(1'b1, 3'b001, 64'h1006, 64'hBEEF, 64'h0, 1'b0, 1'b0, 3, 1'b1);
        wait_done();

        // SB and SD positioning.
        push_beat(64'h2000, 8'h20, 1'b1, 64'h0000_5A00_0000_0000, 64'h0);
        do_req(1'b1, 3'b000, 64'h2005, 64'h5A, 64'h0, 1'b0, 1'b0, 3, 1'b1);
        wait_done();
        push_beat(64'h2008, 8'hFF, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0);
        do_req(1'b1, 3'b011, 64'h2008, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 1'b0, 3, 1'b1);
        wait_done();

        // Load extraction / extension table.
        for (int i = 0; i < 7; i++) begin
            push_beat(64'h2000, ld_tab[i].mask, 1'b0, 64'h0, RW0);
            do_req(1'b0, ld_tab[i].sel, ld_tab[i].addr, 64'h0, ld_tab[i].exp, 1'b1, 1'b0, 3, 1'b1);
            wait_done();
        end

`ifdef LSU_SPLIT_MISALIGN_EN
        push_beat(64'h1000, 8'hF0, 1'b0, 64'h0, 64'h8877_6655_4433_2211);
        push_beat(64'h1008, 8'h0F, 1'b0, 64'h0, 64'h00FF_EEDD_CCBB_AA99);
        do_req(1'b0, 3'b011, 64'h1004, 64'h0, 64'hCCBB_AA99_8877_6655, 1'b1, 1'b0, 5, 1'b1);
        wait_done();
        push_beat(64'h1008, 8'hC0, 1'b1, 64'hBEEF_0000_0000_0000, 64'h0);
        push_beat(64'h1010, 8'h03, 1'b1, 64'h0000_0000_0000_DEAD, 64'h0);
        do_req(1'b1, 3'b010, 64'h100E, 64'hDEAD_BEEF, 64'h0, 1'b0, 1'b0, 5, 1'b1);
        wait_done();
`else
        do_req(1'b0, 3'b011, 64'h1004, 64'h0, 64'h0, 1'b0, 1'b1, 1, 1'b1);
        wait_done();
        do_req(1'b1, 3'b010, 64'h100E, 64'hDEAD_BEEF, 64'h0, 1'b0, 1'b1, 1, 1'b1);
        wait_done();
`endif

        // Backpressure: memory not ready for 5 cycles.
        mem_ready_i = 1'b0;
        push_beat(64'h3000, 8'h0F, 1'b0, 64'h0, 64'h7FFF_0000_1234_5678);
        do_req(1'b0, 3'b010, 64'h3000, 64'h0, 64'h0000_0000_1234_5678, 1'b1, 1'b0, 8, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(mem_valid_o), 64'd1);
            check("bp_addr", mem_addr_o, 64'h3000);
            check("bp_stall", 64'(stall_req_o), 64'd1);
        end
        @(posedge clk);
        #1;
        mem_ready_i = 1'b1;
        wait_done();

        // Reset while waiting for the response; late response must be dropped.
        resp_delay = 1;
        push_beat(64'h4000, 8'h0F, 1'b0, 64'h0, 64'h1234);
        do_req(1'b0, 3'b010, 64'h4000, 64'h0, 64'h0, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstw_ready", 64'(req_ready_o), 64'd1);
        check("rstw_mem_valid", 64'(mem_valid_o), 64'd0);
        check("rstw_stall", 64'(stall_req_o), 64'd0);
        repeat (4) @(negedge clk);
        check("rstw_no_wb", 64'(wb_valid_o), 64'd0);
        resp_delay = 0;
        wait_done();

        // Recovery after reset.
        push_beat(64'h5000, 8'h30, 1'b0, 64'h0, 64'h0000_8001_0000_0000);
        do_req(1'b0, 3'b101, 64'h5004, 64'h0, 64'h0000_0000_0000_8001, 1'b1, 1'b0, 3, 1'b1);
        wait_done();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
